// File: rtl/echo_indication_serializer.sv
// ============================================================================
// echo_indication_serializer: buffers heard(meth, v) calls in a small FIFO and
// streams each one as a 3-beat message (header, meth, v).  Rev 1.0
// ============================================================================
`default_nettype none

module echo_indication_serializer #(
    parameter int          DEPTH     = 2,
    parameter logic [15:0] METHOD_ID = 16'h0000,
    parameter int          CNT_WIDTH = 16
) (
    input  logic                 CLK,
    input  logic                 nRST,
    input  logic                 heard__ENA,
    input  logic [31:0]          heard_meth,
    input  logic [31:0]          heard_v,
    output logic                 heard__RDY,
    output logic                 beat__ENA,
    output logic [31:0]          beat_data,
    output logic                 beat_last,
    input  logic                 beat__RDY,
    output logic [CNT_WIDTH-1:0] msg_count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_HDR  = 2'd1;
    localparam logic [1:0] S_METH = 2'd2;
    localparam logic [1:0] S_VAL  = 2'd3;

    logic [1:0]    state;
    logic [31:0]   meth_mem [DEPTH];
    logic [31:0]   v_mem    [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic [AW:0]   count_next;
    logic          push;
    logic          pop;

    assign heard__RDY = nRST & (count != FULL_COUNT);
    assign push       = heard__ENA & heard__RDY;
    assign pop        = (state == S_VAL) & beat__RDY;

    always_comb begin
        count_next = count;
        if (push && !pop) begin
            count_next = count + (AW+1)'(1);
        end else if (!push && pop) begin
            count_next = count - (AW+1)'(1);
        end
    end

    // Storage needs no reset; only the pointers and count define validity.
    always_ff @(posedge CLK) begin
        if (push) begin
            meth_mem[wr_ptr] <= heard_meth;
            v_mem[wr_ptr]    <= heard_v;
        end
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            state     <= S_IDLE;
            msg_count <= '0;
        end else begin
            count <= count_next;
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case (state)
                S_IDLE: if (count != '0) state <= S_HDR;
                S_HDR:  if (beat__RDY) state <= S_METH;
                S_METH: if (beat__RDY) state <= S_VAL;
                S_VAL: begin
                    if (beat__RDY) begin
                        msg_count <= msg_count + CNT_WIDTH'(1);
                        state     <= (count_next != '0) ? S_HDR : S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        beat__ENA = (state != S_IDLE);
        beat_last = (state == S_VAL);
        beat_data = '0;
        case (state)
            S_HDR:   beat_data = {METHOD_ID, 16'd3};
            S_METH:  beat_data = meth_mem[rd_ptr];
            S_VAL:   beat_data = v_mem[rd_ptr];
            default: beat_data = '0;
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_echo_indication_serializer.sv
// ============================================================================
// tb_echo_indication_serializer: scoreboard bench for the indication
// serializer; a second instance with a 4-bit counter exercises wrap.  Rev 1.0
// ============================================================================
`default_nettype none

module tb_echo_indication_serializer;

    logic        CLK = 1'b0;
    logic        nRST = 1'b0;
    logic        heard__ENA = 1'b0;
    logic [31:0] heard_meth = '0;
    logic [31:0] heard_v = '0;
    logic        beat__RDY = 1'b0;
    logic        heard__RDY;
    logic        beat__ENA;
    logic [31:0] beat_data;
    logic        beat_last;
    logic [15:0] msg_count;

    logic        heard__RDY4;
    logic        beat__ENA4;
    logic [31:0] beat_data4;
    logic        beat_last4;
    logic [3:0]  msg_count4;

    int n_cmp = 0;
    int n_bad = 0;

    logic [32:0] sb [$];
    logic        stall_prev = 1'b0;
    logic [32:0] beat_prev = '0;

    always #5 CLK = ~CLK;

    echo_indication_serializer dut (
        .CLK(CLK), .nRST(nRST),
        .heard__ENA(heard__ENA), .heard_meth(heard_meth), .heard_v(heard_v),
        .heard__RDY(heard__RDY),
        .beat__ENA(beat__ENA), .beat_data(beat_data), .beat_last(beat_last),
        .beat__RDY(beat__RDY), .msg_count(msg_count)
    );

    echo_indication_serializer #(.CNT_WIDTH(4)) dut4 (
        .CLK(CLK), .nRST(nRST),
        .heard__ENA(heard__ENA), .heard_meth(heard_meth), .heard_v(heard_v),
        .heard__RDY(heard__RDY4),
        .beat__ENA(beat__ENA4), .beat_data(beat_data4), .beat_last(beat_last4),
        .beat__RDY(beat__RDY), .msg_count(msg_count4)
    );

    task automatic chk(input string tag, input logic [32:0] got, input logic [32:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h expected=%h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Transfers and pushes both take effect at the next rising edge, so the
    // falling edge sees exactly what the DUT will act on.
    always @(negedge CLK) begin
        if (!nRST) begin
            sb.delete();
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                chk("hold_ena", {32'd0, beat__ENA}, 33'd1);
                chk("hold_beat", {beat_last, beat_data}, beat_prev);
            end
            if (beat__ENA && beat__RDY) begin
                if (sb.size() == 0) begin
                    chk("sb_nonempty", 33'(sb.size()), 33'd1);
                end else begin
                    chk("beat", {beat_last, beat_data}, sb.pop_front());
                end
            end
            stall_prev = beat__ENA && !beat__RDY;
            beat_prev  = {beat_last, beat_data};
            if (heard__ENA && heard__RDY) begin
                sb.push_back({1'b0, 32'h0000_0003});
                sb.push_back({1'b0, heard_meth});
                sb.push_back({1'b1, heard_v});
            end
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        nRST = 1'b0;
        heard__ENA = 1'b0;
        beat__RDY = 1'b0;
        tick();
        tick();
        nRST = 1'b1;
        tick();
    endtask

    task automatic drive_call(input logic [31:0] m, input logic [31:0] v);
        heard__ENA = 1'b1;
        heard_meth = m;
        heard_v    = v;
    endtask

    task automatic drain();
        int idle_run = 0;
        for (int i = 0; i < 200 && idle_run < 2; i++) begin
            tick();
            idle_run = beat__ENA ? 0 : idle_run + 1;
        end
        chk("drain_idle", 33'(idle_run >= 2), 33'd1);
        chk("sb_empty", 33'(sb.size()), 33'd0);
    endtask

    initial begin
        int beats;
        int accepted;
        logic acc;

        // Test 1: reset values and single-message latency
        nRST = 1'b0;
        tick();
        tick();
        tick();
        chk("rst_heard_rdy", {32'd0, heard__RDY}, 33'd0);
        chk("rst_beat_ena", {32'd0, beat__ENA}, 33'd0);
        chk("rst_beat", {beat_last, beat_data}, 33'd0);
        chk("rst_count", 33'(msg_count), 33'd0);
        nRST = 1'b1;
        tick();
        chk("rel_heard_rdy", {32'd0, heard__RDY}, 33'd1);
        beat__RDY = 1'b1;
        drive_call(32'h1, 32'hCAFE);
        tick();
        heard__ENA = 1'b0;
        chk("t1_n1_ena", {32'd0, beat__ENA}, 33'd0);
        tick();
        chk("t1_hdr", {beat__ENA, beat_last, beat_data}, {2'b10, 32'h0000_0003});
        tick();
        chk("t1_meth", {beat__ENA, beat_last, beat_data}, {2'b10, 32'h1});
        tick();
        chk("t1_val", {beat__ENA, beat_last, beat_data}, {2'b11, 32'hCAFE});
        tick();
        chk("t1_count", 33'(msg_count), 33'd1);
        chk("t1_idle", {32'd0, beat__ENA}, 33'd0);

        // Test 2: back-pressure during METH
        do_reset();
        beat__RDY = 1'b1;
        drive_call(32'hA5A5_0001, 32'h5A5A_0002);
        tick();
        heard__ENA = 1'b0;
        tick();
        tick();
        beat__RDY = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t2_hold", {beat__ENA, beat_last, beat_data}, {2'b10, 32'hA5A5_0001});
        end
        beat__RDY = 1'b1;
        tick();
        chk("t2_val", {beat__ENA, beat_last, beat_data}, {2'b11, 32'h5A5A_0002});
        tick();
        chk("t2_count", 33'(msg_count), 33'd1);

        // Test 3: fill the FIFO; the third call is refused
        do_reset();
        drive_call(32'h10, 32'h11);
        tick();
        chk("t3_rdy1", {32'd0, heard__RDY}, 33'd1);
        drive_call(32'h20, 32'h21);
        tick();
        chk("t3_full", {32'd0, heard__RDY}, 33'd0);
        drive_call(32'h30, 32'h31);
        tick();
        heard__ENA = 1'b0;
        chk("t3_still_full", {32'd0, heard__RDY}, 33'd0);
        beat__RDY = 1'b1;
        beats = 0;
        for (int i = 0; i < 20; i++) begin
            if (beat__ENA) beats++;
            tick();
        end
        chk("t3_beats", 33'(beats), 33'd6);
        chk("t3_count", 33'(msg_count), 33'd2);

        // Test 4: back-to-back messages without an idle cycle
        do_reset();
        drive_call(32'h40, 32'h41);
        tick();
        drive_call(32'h50, 32'h51);
        tick();
        heard__ENA = 1'b0;
        tick();
        beat__RDY = 1'b1;
        for (int i = 0; i < 6; i++) begin
            chk("t4_b2b", {31'd0, beat__ENA, beat_last}, {31'd0, 1'b1, 1'(i == 2 || i == 5)});
            tick();
        end
        chk("t4_end", {32'd0, beat__ENA}, 33'd0);
        chk("t4_count", 33'(msg_count), 33'd2);

        // Test 5: push offered on the VAL pop cycle while full
        do_reset();
        drive_call(32'h60, 32'h61);
        tick();
        drive_call(32'h70, 32'h71);
        tick();
        heard__ENA = 1'b0;
        tick();
        beat__RDY = 1'b1;
        tick();
        tick();
        drive_call(32'h80, 32'h81);
        #1;
        chk("t5_val_state", {32'd0, beat_last}, 33'd1);
        chk("t5_no_bypass", {32'd0, heard__RDY}, 33'd0);
        tick();
        chk("t5_rdy_after_pop", {32'd0, heard__RDY}, 33'd1);
        tick();
        heard__ENA = 1'b0;
        drain();
        chk("t5_count", 33'(msg_count), 33'd3);

        // Test 6: reset during METH abandons everything
        do_reset();
        drive_call(32'h90, 32'h91);
        tick();
        drive_call(32'hA0, 32'hA1);
        tick();
        heard__ENA = 1'b0;
        tick();
        beat__RDY = 1'b1;
        tick();
        chk("t6_in_meth", {beat__ENA, beat_last, beat_data}, {2'b10, 32'h90});
        nRST = 1'b0;
        tick();
        chk("t6_rst_ena", {32'd0, beat__ENA}, 33'd0);
        chk("t6_rst_count", 33'(msg_count), 33'd0);
        nRST = 1'b1;
        tick();
        chk("t6_rel_rdy", {32'd0, heard__RDY}, 33'd1);
        tick();
        tick();
        chk("t6_empty", {32'd0, beat__ENA}, 33'd0);

        // Wrap: 16 messages; the 4-bit counter returns to zero
        do_reset();
        beat__RDY = 1'b1;
        accepted = 0;
        for (int i = 0; i < 400 && accepted < 16; i++) begin
            drive_call(32'h100 + 32'(accepted), 32'h200 + 32'(accepted));
            #1;
            acc = heard__RDY;
            tick();
            if (acc) accepted++;
        end
        heard__ENA = 1'b0;
        chk("wrap_accepted", 33'(accepted), 33'd16);
        drain();
        chk("wrap_count16", 33'(msg_count), 33'd16);
        chk("wrap_count4", 33'(msg_count4), 33'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got=running expected=finished");
        $fatal(1, "bench timeout");
    end

endmodule

`default_nettype wire
